// File: rtl/rv32i_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_ex_operand_stage
// Purpose  : ID/EX pipeline slot plus operand selection and forwarding for
//            rv32i_alu. A decoded instruction is accepted with a valid/ready
//            handshake. RAW hazards are resolved by forwarding from MEM (which
//            has priority) and then WB. A load-use hazard holds the slot for
//            one cycle. A flush discards the held instruction and any
//            instruction offered in the same cycle.
// Ports    : clk, rst_n                 clock, asynchronous active-low reset
//            flush_i                    discard held and incoming instruction
//            id_*_i / id_ready_o        decoded instruction handshake and fields
//            mem_*_i, wb_*_i            forwarding sources from MEM and WB
//            ex_valid_o / ex_ready_i    downstream handshake
//            alu_op_o/in1_o/in2_o       ALU operands
//            ex_store_data_o            forwarded rs2 (store data, branch compare)
//            ex_rd_addr_o/ex_rd_we_o    registered destination
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_ex_operand_stage #(
  parameter int XLEN = 32,
  parameter int OPW  = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush_i,
  input  logic            id_valid_i,
  output logic            id_ready_o,
  input  logic [OPW-1:0]  id_op_i,
  input  logic [XLEN-1:0] id_pc_i,
  input  logic [XLEN-1:0] id_imm_i,
  input  logic [4:0]      id_rs1_addr_i,
  input  logic [4:0]      id_rs2_addr_i,
  input  logic [XLEN-1:0] id_rs1_data_i,
  input  logic [XLEN-1:0] id_rs2_data_i,
  input  logic            id_sel_pc_i,
  input  logic            id_sel_imm_i,
  input  logic [4:0]      id_rd_addr_i,
  input  logic            id_rd_we_i,
  input  logic [4:0]      mem_rd_addr_i,
  input  logic            mem_rd_we_i,
  input  logic            mem_is_load_i,
  input  logic [XLEN-1:0] mem_rd_data_i,
  input  logic [4:0]      wb_rd_addr_i,
  input  logic            wb_rd_we_i,
  input  logic [XLEN-1:0] wb_rd_data_i,
  output logic            ex_valid_o,
  input  logic            ex_ready_i,
  output logic [OPW-1:0]  alu_op_o,
  output logic [XLEN-1:0] alu_in1_o,
  output logic [XLEN-1:0] alu_in2_o,
  output logic [XLEN-1:0] ex_store_data_o,
  output logic [4:0]      ex_rd_addr_o,
  output logic            ex_rd_we_o
);

  localparam logic [4:0] c_X0 = 5'd0;

  // Registered slot
  logic            valid_q,    valid_d;
  logic [OPW-1:0]  op_q,       op_d;
  logic [XLEN-1:0] pc_q,       pc_d;
  logic [XLEN-1:0] imm_q,      imm_d;
  logic [4:0]      rs1_addr_q, rs1_addr_d;
  logic [4:0]      rs2_addr_q, rs2_addr_d;
  logic [XLEN-1:0] rs1_data_q, rs1_data_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic            sel_pc_q,   sel_pc_d;
  logic            sel_imm_q,  sel_imm_d;
  logic [4:0]      rd_addr_q,  rd_addr_d;
  logic            rd_we_q,    rd_we_d;

  logic            w_hazard;
  logic            w_fire_out;
  logic            w_accept;
  logic [XLEN-1:0] w_fwd1;
  logic [XLEN-1:0] w_fwd2;

  // Forwarding: a load in MEM has no data yet, so it is skipped here and the
  // hazard logic stalls instead. x0 always reads the captured regfile value.
  always_comb begin
    w_fwd1 = rs1_data_q;
    if (rs1_addr_q != c_X0) begin
      if (mem_rd_we_i && !mem_is_load_i && (mem_rd_addr_i == rs1_addr_q)) begin
        w_fwd1 = mem_rd_data_i;
      end else if (wb_rd_we_i && (wb_rd_addr_i == rs1_addr_q)) begin
        w_fwd1 = wb_rd_data_i;
      end
    end
  end

  always_comb begin
    w_fwd2 = rs2_data_q;
    if (rs2_addr_q != c_X0) begin
      if (mem_rd_we_i && !mem_is_load_i && (mem_rd_addr_i == rs2_addr_q)) begin
        w_fwd2 = mem_rd_data_i;
      end else if (wb_rd_we_i && (wb_rd_addr_i == rs2_addr_q)) begin
        w_fwd2 = wb_rd_data_i;
      end
    end
  end

  // rs1 only matters when in1 is not the PC. rs2 always matters because it
  // also feeds the store-data / branch-compare output even when in2 is imm.
  always_comb begin
    w_hazard = 1'b0;
    if (valid_q && mem_rd_we_i && mem_is_load_i && (mem_rd_addr_i != c_X0)) begin
      w_hazard = ((!sel_pc_q) && (mem_rd_addr_i == rs1_addr_q)) ||
                 (mem_rd_addr_i == rs2_addr_q);
    end
  end

  assign ex_valid_o = valid_q && !w_hazard;
  assign w_fire_out = ex_valid_o && ex_ready_i;
  assign id_ready_o = !flush_i && (!valid_q || w_fire_out);
  assign w_accept   = id_valid_i && id_ready_o;

  // Slot next state; flush has priority over accept (id_ready is already low).
  always_comb begin
    valid_d    = valid_q;
    op_d       = op_q;
    pc_d       = pc_q;
    imm_d      = imm_q;
    rs1_addr_d = rs1_addr_q;
    rs2_addr_d = rs2_addr_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    sel_pc_d   = sel_pc_q;
    sel_imm_d  = sel_imm_q;
    rd_addr_d  = rd_addr_q;
    rd_we_d    = rd_we_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (w_accept) begin
      valid_d    = 1'b1;
      op_d       = id_op_i;
      pc_d       = id_pc_i;
      imm_d      = id_imm_i;
      rs1_addr_d = id_rs1_addr_i;
      rs2_addr_d = id_rs2_addr_i;
      rs1_data_d = id_rs1_data_i;
      rs2_data_d = id_rs2_data_i;
      sel_pc_d   = id_sel_pc_i;
      sel_imm_d  = id_sel_imm_i;
      rd_addr_d  = id_rd_addr_i;
      rd_we_d    = id_rd_we_i;
    end else if (w_fire_out) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      op_q       <= '0;
      pc_q       <= '0;
      imm_q      <= '0;
      rs1_addr_q <= '0;
      rs2_addr_q <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      sel_pc_q   <= 1'b0;
      sel_imm_q  <= 1'b0;
      rd_addr_q  <= '0;
      rd_we_q    <= 1'b0;
    end else begin
      valid_q    <= valid_d;
      op_q       <= op_d;
      pc_q       <= pc_d;
      imm_q      <= imm_d;
      rs1_addr_q <= rs1_addr_d;
      rs2_addr_q <= rs2_addr_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      sel_pc_q   <= sel_pc_d;
      sel_imm_q  <= sel_imm_d;
      rd_addr_q  <= rd_addr_d;
      rd_we_q    <= rd_we_d;
    end
  end

  assign alu_op_o        = op_q;
  assign alu_in1_o       = sel_pc_q  ? pc_q  : w_fwd1;
  assign alu_in2_o       = sel_imm_q ? imm_q : w_fwd2;
  assign ex_store_data_o = w_fwd2;
  assign ex_rd_addr_o    = rd_addr_q;
  assign ex_rd_we_o      = rd_we_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_ex_operand_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_ex_operand_stage
// Purpose  : Self-checking bench for rv32i_ex_operand_stage. Expected ALU
//            packets are queued when an instruction is driven and popped when
//            the stage presents it downstream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_ex_operand_stage;

  localparam int XLEN = 32;
  localparam int OPW  = 4;
  localparam int EW   = OPW + 3*XLEN + 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush, id_valid, id_ready;
  logic [OPW-1:0]  id_op;
  logic [XLEN-1:0] id_pc, id_imm, id_rs1_data, id_rs2_data;
  logic [4:0]      id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic            id_sel_pc, id_sel_imm, id_rd_we;
  logic [4:0]      mem_rd_addr, wb_rd_addr;
  logic            mem_rd_we, mem_is_load, wb_rd_we;
  logic [XLEN-1:0] mem_rd_data, wb_rd_data;
  logic            ex_valid, ex_ready;
  logic [OPW-1:0]  alu_op;
  logic [XLEN-1:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]      ex_rd_addr;
  logic            ex_rd_we;

  int n_checks = 0;
  int n_fail   = 0;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp_v;
  logic [EW-1:0] obs;

  assign obs = {alu_op, alu_in1, alu_in2, ex_store_data, ex_rd_addr, ex_rd_we};

  always #5 clk = ~clk;

  rv32i_ex_operand_stage #(.XLEN(XLEN), .OPW(OPW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .flush_i        (flush),
    .id_valid_i     (id_valid),
    .id_ready_o     (id_ready),
    .id_op_i        (id_op),
    .id_pc_i        (id_pc),
    .id_imm_i       (id_imm),
    .id_rs1_addr_i  (id_rs1_addr),
    .id_rs2_addr_i  (id_rs2_addr),
    .id_rs1_data_i  (id_rs1_data),
    .id_rs2_data_i  (id_rs2_data),
    .id_sel_pc_i    (id_sel_pc),
    .id_sel_imm_i   (id_sel_imm),
    .id_rd_addr_i   (id_rd_addr),
    .id_rd_we_i     (id_rd_we),
    .mem_rd_addr_i  (mem_rd_addr),
    .mem_rd_we_i    (mem_rd_we),
    .mem_is_load_i  (mem_is_load),
    .mem_rd_data_i  (mem_rd_data),
    .wb_rd_addr_i   (wb_rd_addr),
    .wb_rd_we_i     (wb_rd_we),
    .wb_rd_data_i   (wb_rd_data),
    .ex_valid_o     (ex_valid),
    .ex_ready_i     (ex_ready),
    .alu_op_o       (alu_op),
    .alu_in1_o      (alu_in1),
    .alu_in2_o      (alu_in2),
    .ex_store_data_o(ex_store_data),
    .ex_rd_addr_o   (ex_rd_addr),
    .ex_rd_we_o     (ex_rd_we)
  );

  function automatic logic [EW-1:0] pack(input logic [OPW-1:0] op, input logic [XLEN-1:0] a,
                                         input logic [XLEN-1:0] b, input logic [XLEN-1:0] s,
                                         input logic [4:0] rd, input logic we);
    return {op, a, b, s, rd, we};
  endfunction

  task automatic set_id(input logic [OPW-1:0] op, input logic [XLEN-1:0] pc, input logic [XLEN-1:0] imm,
                        input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [XLEN-1:0] d1, input logic [XLEN-1:0] d2,
                        input logic spc, input logic simm, input logic [4:0] rd, input logic we);
    id_op = op; id_pc = pc; id_imm = imm; id_rs1_addr = rs1; id_rs2_addr = rs2;
    id_rs1_data = d1; id_rs2_data = d2; id_sel_pc = spc; id_sel_imm = simm;
    id_rd_addr = rd; id_rd_we = we;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_fwd();
    mem_rd_addr = 5'd0; mem_rd_we = 1'b0; mem_is_load = 1'b0; mem_rd_data = '0;
    wb_rd_addr = 5'd0; wb_rd_we = 1'b0; wb_rd_data = '0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid: got %b want 0", ex_valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %h want 0", obs); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_id_ready: got %b want 1", id_ready); end
    // hold an instruction, then reset asynchronously mid-cycle
    ex_ready = 1'b0;
    set_id(4'd2, 32'h100, 32'h0, 5'd0, 5'd0, '0, '0, 1'b1, 1'b0, 5'd9, 1'b1);
    id_valid = 1'b1; tick(); id_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ex_valid !== 1'b1 || alu_in1 !== 32'h100) begin n_fail++;
      $display("FAIL hold_before_reset: got valid=%b in1=%h want valid=1 in1=00000100", ex_valid, alu_in1); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL async_reset_ex_valid: got %b want 0", ex_valid); end
    n_checks++; if (obs !== '0) begin n_fail++; $display("FAIL async_reset_outputs: got %h want 0", obs); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    ex_ready = 1'b1;
    n_checks++; if (id_ready !== 1'b1 || ex_valid !== 1'b0) begin n_fail++;
      $display("FAIL after_reset_release: got ready=%b valid=%b want ready=1 valid=0", id_ready, ex_valid); end
  endtask

  task automatic test_forward_mem();
    // ADDI x5,x0,7
    set_id(4'd0, 32'h0, 32'd7, 5'd0, 5'd0, '0, '0, 1'b0, 1'b1, 5'd5, 1'b1);
    exp_q.push_back(pack(4'd0, 32'd0, 32'd7, 32'd0, 5'd5, 1'b1));
    id_valid = 1'b1; tick();
    // ADD x6,x5,x5 with stale regfile data; ADDI result now in MEM
    set_id(4'd0, 32'h4, 32'h0, 5'd5, 5'd5, '0, '0, 1'b0, 1'b0, 5'd6, 1'b1);
    exp_q.push_back(pack(4'd0, 32'd7, 32'd7, 32'd7, 5'd6, 1'b1));
    mem_rd_addr = 5'd5; mem_rd_we = 1'b1; mem_rd_data = 32'd7;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL addi_out: got %h want %h", obs, exp_v); end
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL fwd_no_stall: got id_ready=%b want 1", id_ready); end
    tick(); id_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL add_mem_fwd: got %h want %h", obs, exp_v); end
    tick(); clear_fwd();
  endtask

  task automatic test_priority();
    // MEM and WB both write x3: MEM wins
    set_id(4'd3, 32'h0, 32'h0, 5'd3, 5'd0, 32'h99, '0, 1'b0, 1'b0, 5'd8, 1'b1);
    exp_q.push_back(pack(4'd3, 32'h11, 32'h0, 32'h0, 5'd8, 1'b1));
    id_valid = 1'b1; tick(); id_valid = 1'b0;
    mem_rd_addr = 5'd3; mem_rd_we = 1'b1; mem_rd_data = 32'h11;
    wb_rd_addr = 5'd3; wb_rd_we = 1'b1; wb_rd_data = 32'h22;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL mem_priority: got %h want %h", obs, exp_v); end
    tick(); clear_fwd();
    // sources are x0: nothing forwarded even though MEM/WB claim x0
    set_id(4'd4, 32'h0, 32'h0, 5'd0, 5'd0, '0, '0, 1'b0, 1'b0, 5'd9, 1'b1);
    exp_q.push_back(pack(4'd4, 32'h0, 32'h0, 32'h0, 5'd9, 1'b1));
    id_valid = 1'b1; tick(); id_valid = 1'b0;
    mem_rd_addr = 5'd0; mem_rd_we = 1'b1; mem_rd_data = 32'h33;
    wb_rd_addr = 5'd0; wb_rd_we = 1'b1; wb_rd_data = 32'h44;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL x0_no_fwd: got %h want %h", obs, exp_v); end
    tick(); clear_fwd();
    // WB only; in2 is imm but store data still gets forwarded rs2
    set_id(4'd1, 32'h0, 32'h40, 5'd3, 5'd3, 32'h99, 32'h99, 1'b0, 1'b1, 5'd10, 1'b1);
    exp_q.push_back(pack(4'd1, 32'h22, 32'h40, 32'h22, 5'd10, 1'b1));
    id_valid = 1'b1; tick(); id_valid = 1'b0;
    wb_rd_addr = 5'd3; wb_rd_we = 1'b1; wb_rd_data = 32'h22;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (obs !== exp_v) begin n_fail++; $display("FAIL wb_fwd_store: got %h want %h", obs, exp_v); end
    tick(); clear_fwd();
  endtask

  task automatic test_load_use();
    // ADD x7,x4,x1 while LW x4 is in MEM
    set_id(4'd0, 32'h0, 32'h0, 5'd4, 5'd1, '0, 32'h10, 1'b0, 1'b0, 5'd7, 1'b1);
    exp_q.push_back(pack(4'd0, 32'hDEADBEEF, 32'h10, 32'h10, 5'd7, 1'b1));
    id_valid = 1'b1; tick();
    mem_rd_addr = 5'd4; mem_rd_we = 1'b1; mem_is_load = 1'b1; mem_rd_data = 32'hBAD;
    set_id(4'd5, 32'h200, 32'd4, 5'd0, 5'd0, '0, '0, 1'b1, 1'b1, 5'd1, 1'b1);
    exp_q.push_back(pack(4'd5, 32'h200, 32'd4, 32'h0, 5'd1, 1'b1));
    @(negedge clk);
    n_checks++; if (ex_valid !== 1'b0 || id_ready !== 1'b0) begin n_fail++;
      $display("FAIL load_use_stall: got valid=%b ready=%b want 0 0", ex_valid, id_ready); end
    tick();
    mem_rd_we = 1'b0; mem_is_load = 1'b0;
    wb_rd_addr = 5'd4; wb_rd_we = 1'b1; wb_rd_data = 32'hDEADBEEF;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL load_use_wb_fwd: got %h want %h", obs, exp_v); end
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_release: got id_ready=%b want 1", id_ready); end
    tick(); id_valid = 1'b0; clear_fwd();
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL after_stall_next: got %h want %h", obs, exp_v); end
    tick();
  endtask

  task automatic test_stall();
    ex_ready = 1'b0;
    set_id(4'd6, 32'h500, 32'd8, 5'd0, 5'd0, '0, '0, 1'b1, 1'b1, 5'd13, 1'b1);
    exp_q.push_back(pack(4'd6, 32'h500, 32'd8, 32'h0, 5'd13, 1'b1));
    id_valid = 1'b1; tick();
    set_id(4'd7, 32'h504, 32'd9, 5'd0, 5'd0, '0, '0, 1'b1, 1'b1, 5'd14, 1'b1);
    exp_q.push_back(pack(4'd7, 32'h504, 32'd9, 32'h0, 5'd14, 1'b1));
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_v = exp_q[0];
      n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v || id_ready !== 1'b0) begin n_fail++;
        $display("FAIL stall_hold[%0d]: got %h ready=%b want %h ready=0", k, obs, id_ready, exp_v); end
    end
    ex_ready = 1'b1;
    #1;
    exp_v = exp_q.pop_front();
    n_checks++; if (id_ready !== 1'b1 || obs !== exp_v) begin n_fail++;
      $display("FAIL stall_release: got %h ready=%b want %h ready=1", obs, id_ready, exp_v); end
    tick(); id_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL stall_next: got %h want %h", obs, exp_v); end
    tick();
  endtask

  task automatic test_back_to_back();
    ex_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_id(4'(i), 32'h1000 + 32'(4*i), 32'(3*i), 5'd0, 5'd0, '0, '0, 1'b1, 1'b1, 5'(i+1), 1'b1);
      exp_q.push_back(pack(4'(i), 32'h1000 + 32'(4*i), 32'(3*i), 32'h0, 5'(i+1), 1'b1));
      id_valid = 1'b1;
      @(negedge clk);
      if (i > 0) begin
        exp_v = exp_q.pop_front();
        n_checks++; if (ex_valid !== 1'b1 || id_ready !== 1'b1 || obs !== exp_v) begin n_fail++;
          $display("FAIL b2b[%0d]: got %h valid=%b ready=%b want %h", i, obs, ex_valid, id_ready, exp_v); end
      end
      tick();
    end
    id_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL b2b_last: got %h want %h", obs, exp_v); end
    tick();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got ex_valid=%b want 0", ex_valid); end
  endtask

  task automatic test_flush();
    ex_ready = 1'b0;
    set_id(4'd2, 32'h300, 32'h0, 5'd0, 5'd0, '0, '0, 1'b1, 1'b0, 5'd11, 1'b1);
    id_valid = 1'b1; tick();
    flush = 1'b1;
    set_id(4'd3, 32'h400, 32'h0, 5'd0, 5'd0, '0, '0, 1'b1, 1'b0, 5'd12, 1'b1);
    @(negedge clk);
    n_checks++; if (id_ready !== 1'b0) begin n_fail++; $display("FAIL flush_id_ready: got %b want 0", id_ready); end
    tick(); flush = 1'b0; id_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL flush_ex_valid: got %b want 0", ex_valid); end
    n_checks++; if (alu_in1 === 32'h400 || ex_rd_addr === 5'd12) begin n_fail++;
      $display("FAIL flush_not_captured: got in1=%h rd=%0d, flushed instr must not load", alu_in1, ex_rd_addr); end
    n_checks++; if (id_ready !== 1'b1) begin n_fail++; $display("FAIL flush_recover_ready: got %b want 1", id_ready); end
    ex_ready = 1'b1;
    tick();
    set_id(4'd2, 32'h600, 32'd1, 5'd0, 5'd0, '0, '0, 1'b1, 1'b1, 5'd15, 1'b1);
    exp_q.push_back(pack(4'd2, 32'h600, 32'd1, 32'h0, 5'd15, 1'b1));
    id_valid = 1'b1; tick(); id_valid = 1'b0;
    @(negedge clk);
    exp_v = exp_q.pop_front();
    n_checks++; if (ex_valid !== 1'b1 || obs !== exp_v) begin n_fail++; $display("FAIL flush_recover: got %h want %h", obs, exp_v); end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
    set_id('0, '0, '0, 5'd0, 5'd0, '0, '0, 1'b0, 1'b0, 5'd0, 1'b0);
    clear_fwd();
    test_reset();
    test_forward_mem();
    test_priority();
    test_load_use();
    test_stall();
    test_back_to_back();
    test_flush();
    n_checks++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL scoreboard_empty: got %0d left want 0", exp_q.size()); end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
